// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: client IDs, FSM states,
// default beat index width and the rotating-priority pick helper used when
// ARB_ROUND_ROBIN_EN is defined.
package mem_arb_pkg;

   localparam int NUM_CLIENTS          = 3;
   localparam int WORDS_PER_LINE_DFLT  = 8;
   localparam int BEAT_W               = $clog2(WORDS_PER_LINE_DFLT);

   typedef enum logic [1:0] {
      CL_DF = 2'd0,
      CL_IF = 2'd1,
      CL_DW = 2'd2
   } client_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARB   = 2'd1,
      ST_BURST = 2'd2
   } state_e;

   // Next client in DF -> IF -> DW order after 'last' that is requesting.
   function automatic client_e rr_pick(input client_e last, input logic [2:0] req);
      client_e c    = last;
      client_e pick = last;
      logic    hit  = 1'b0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         c = (c == CL_DW) ? CL_DF : client_e'(c + 2'd1);
         if (!hit && req[c]) begin
            pick = c;
            hit  = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/arb_beat_counter.sv
// Beat counter with wrap-around word index. 'load' restarts a burst at
// start_word; each 'ack' advances both the beat count and the word index,
// the index wrapping naturally from the last word of the line to word 0.
module arb_beat_counter #(
   parameter  int WORDS_PER_LINE = 8,
   localparam int BW             = $clog2(WORDS_PER_LINE)
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic [BW-1:0] start_word,
   input  logic          load,
   input  logic          ack,
   output logic [BW-1:0] beat,
   output logic [BW-1:0] word,
   output logic          last
);

   // Burst position: cleared on load, stepped on each accepted beat.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         beat <= '0;
         word <= '0;
      end else if (load) begin
         beat <= '0;
         word <= start_word;
      end else if (ack) begin
         beat <= beat + 1'b1;
         word <= word + 1'b1;
      end
   end

   assign last = (beat == BW'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between the D-cache fill (DF), I-cache
// fill (IF) and D-cache write-back (DW) buffers, one line burst at a time.
// Reads run critical-word-first with wrap; writes run from word 0.
// Build option: ARB_ROUND_ROBIN_EN selects rotating priority instead of
// fixed DF > IF > DW priority with the MAX_SKIP write-back starvation guard.
module mem_port_arbiter import mem_arb_pkg::*; #(
   parameter int WORDS_PER_LINE = 8,
   parameter int ADDR_W         = 32,
   parameter int MAX_SKIP       = 4
) (
   input  logic                              Clk,
   input  logic                              Rst,
   input  logic                              DF_Req,
   input  logic [ADDR_W-1:0]                 DF_Addr,
   output logic                              DF_Gnt,
   output logic                              DF_FirstWord,
   output logic                              DF_Completed,
   input  logic                              IF_Req,
   input  logic [ADDR_W-1:0]                 IF_Addr,
   output logic                              IF_Gnt,
   output logic                              IF_FirstWord,
   output logic                              IF_Completed,
   input  logic                              DW_Req,
   input  logic [ADDR_W-1:0]                 DW_Addr,
   input  logic [31:0]                       DW_WData,
   output logic [$clog2(WORDS_PER_LINE)-1:0] DW_Beat,
   output logic                              DW_Gnt,
   output logic                              DW_Completed,
   output logic [31:0]                       RData,
   output logic                              RValid,
   output logic [$clog2(WORDS_PER_LINE)-1:0] RWord,
   output logic                              Mem_Req,
   output logic                              Mem_RW,
   output logic [ADDR_W-1:0]                 Mem_Addr,
   output logic [31:0]                       Mem_WData,
   input  logic [31:0]                       Mem_RData,
   input  logic                              Mem_Ack
);

   localparam int BW       = $clog2(WORDS_PER_LINE);
   localparam int LINE_LSB = BW + 2;
   localparam int LINE_W   = ADDR_W - LINE_LSB;

   state_e            state;
   logic [2:0]        gnt_q;
   logic              mreq_q;
   logic              mrw_q;
   logic [LINE_W-1:0] line_q;

   client_e           win;
   logic [BW-1:0]     win_start;
   logic [LINE_W-1:0] win_line;
   logic              any_req;
   logic              same_line;
   logic              grant;
   logic              beat_ack;
   logic              rd_beat;
   logic [BW-1:0]     beat;
   logic [BW-1:0]     word;
   logic              last_beat;

   assign any_req   = DF_Req | IF_Req | DW_Req;
   // Dirty miss: the write-back must reach memory before the fill reads it.
   assign same_line = DF_Req & DW_Req &
                      (DF_Addr[ADDR_W-1:LINE_LSB] == DW_Addr[ADDR_W-1:LINE_LSB]);
   assign grant     = (state == ST_ARB) & any_req;
   assign beat_ack  = mreq_q & Mem_Ack;
   assign rd_beat   = beat_ack & ~mrw_q;

`ifdef ARB_ROUND_ROBIN_EN
   client_e last_gnt;

   // Remember the last winner; reset value makes DF first in the rotation.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)
         last_gnt <= CL_DW;
      else if (grant)
         last_gnt <= win;
   end

   // Winner selection: same-line override, then rotating priority.
   always_comb begin
      win = CL_DF;
      if (same_line)
         win = CL_DW;
      else
         win = rr_pick(last_gnt, {DW_Req, IF_Req, DF_Req});
   end
`else
   localparam int SKIP_W = $clog2(MAX_SKIP + 1);
   logic [SKIP_W-1:0] skip_cnt;

   // Count reader grants that passed over a waiting write-back.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)
         skip_cnt <= '0;
      else if (!DW_Req)
         skip_cnt <= '0;
      else if (grant) begin
         if (win == CL_DW)
            skip_cnt <= '0;
         else if (skip_cnt != SKIP_W'(MAX_SKIP))
            skip_cnt <= skip_cnt + 1'b1;
      end
   end

   // Winner selection: same-line override, starvation guard, fixed priority.
   always_comb begin
      win = CL_DF;
      if (same_line)
         win = CL_DW;
      else if (DW_Req && skip_cnt == SKIP_W'(MAX_SKIP))
         win = CL_DW;
      else if (DF_Req)
         win = CL_DF;
      else if (IF_Req)
         win = CL_IF;
      else
         win = CL_DW;
   end
`endif

   // Burst origin for the winner: readers start at their critical word.
   always_comb begin
      win_start = '0;
      win_line  = DF_Addr[ADDR_W-1:LINE_LSB];
      case (win)
         CL_DF: begin
            win_start = DF_Addr[LINE_LSB-1:2];
            win_line  = DF_Addr[ADDR_W-1:LINE_LSB];
         end
         CL_IF: begin
            win_start = IF_Addr[LINE_LSB-1:2];
            win_line  = IF_Addr[ADDR_W-1:LINE_LSB];
         end
         default: begin
            win_start = '0;
            win_line  = DW_Addr[ADDR_W-1:LINE_LSB];
         end
      endcase
   end

   arb_beat_counter #(.WORDS_PER_LINE(WORDS_PER_LINE)) u_beat (
      .Clk        (Clk),
      .Rst        (Rst),
      .start_word (win_start),
      .load       (grant),
      .ack        (beat_ack),
      .beat       (beat),
      .word       (word),
      .last       (last_beat)
   );

   // Port sequencer: IDLE -> ARB -> BURST, with registered grant and request.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state  <= ST_IDLE;
         gnt_q  <= '0;
         mreq_q <= 1'b0;
         mrw_q  <= 1'b0;
         line_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_req)
                  state <= ST_ARB;
            end
            ST_ARB: begin
               if (any_req) begin
                  gnt_q  <= 3'b001 << win;
                  mrw_q  <= (win == CL_DW);
                  line_q <= win_line;
                  state  <= ST_BURST;
               end else begin
                  state  <= ST_IDLE;
               end
            end
            ST_BURST: begin
               if (!mreq_q)
                  mreq_q <= 1'b1;
               else if (beat_ack && last_beat) begin
                  mreq_q <= 1'b0;
                  mrw_q  <= 1'b0;
                  gnt_q  <= '0;
                  state  <= any_req ? ST_ARB : ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign DF_Gnt       = gnt_q[CL_DF];
   assign IF_Gnt       = gnt_q[CL_IF];
   assign DW_Gnt       = gnt_q[CL_DW];

   assign DF_FirstWord = rd_beat & gnt_q[CL_DF] & (beat == '0);
   assign IF_FirstWord = rd_beat & gnt_q[CL_IF] & (beat == '0);
   assign DF_Completed = beat_ack & gnt_q[CL_DF] & last_beat;
   assign IF_Completed = beat_ack & gnt_q[CL_IF] & last_beat;
   assign DW_Completed = beat_ack & gnt_q[CL_DW] & last_beat;

   assign RValid       = rd_beat;
   assign RData        = rd_beat ? Mem_RData : '0;
   assign RWord        = rd_beat ? word : '0;

   assign Mem_Req      = mreq_q;
   assign Mem_RW       = mrw_q;
   assign Mem_Addr     = mreq_q ? {line_q, word, 2'b00} : '0;
   assign Mem_WData    = (mreq_q & mrw_q) ? DW_WData : '0;
   assign DW_Beat      = gnt_q[CL_DW] ? beat : '0;

   // Byte offsets below the word, and DW's in-line offset, are don't-care.
   logic unused_addr_bits;
   assign unused_addr_bits = &{1'b0, DF_Addr[1:0], IF_Addr[1:0], DW_Addr[LINE_LSB-1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a beat scoreboard: each request
// pushes its expected beats, the negedge monitor pops and checks them.
module tb_mem_port_arbiter;

   localparam int WPL    = 8;
   localparam int ADDR_W = 32;
   localparam int BW     = 3;

   logic              Clk = 1'b0;
   logic              Rst = 1'b0;
   logic              DF_Req = 1'b0, IF_Req = 1'b0, DW_Req = 1'b0;
   logic [ADDR_W-1:0] DF_Addr = '0, IF_Addr = '0, DW_Addr = '0;
   logic [31:0]       DW_WData;
   logic [BW-1:0]     DW_Beat, RWord;
   logic              DF_Gnt, DF_FirstWord, DF_Completed;
   logic              IF_Gnt, IF_FirstWord, IF_Completed;
   logic              DW_Gnt, DW_Completed;
   logic [31:0]       RData, Mem_WData, Mem_RData;
   logic              RValid, Mem_Req, Mem_RW, Mem_Ack;
   logic [ADDR_W-1:0] Mem_Addr;
   logic              ack_en = 1'b1;
   logic              prev_cpl = 1'b0;

   typedef struct {
      logic        rw;
      logic [31:0] addr;
      int          owner;
      int          beat;
      int          word;
   } beat_t;

   beat_t sb[$];
   int    checks = 0;
   int    errors = 0;

   always #5 Clk = ~Clk;

   function automatic logic [31:0] rd_data(input logic [31:0] a);
      return a ^ 32'h5A5A_A5A5;
   endfunction

   assign Mem_Ack   = Mem_Req & ack_en;
   assign Mem_RData = rd_data(Mem_Addr);
   assign DW_WData  = 32'hD000_0000 | {29'd0, DW_Beat};

   mem_port_arbiter #(.WORDS_PER_LINE(WPL), .ADDR_W(ADDR_W), .MAX_SKIP(4)) dut (
      .Clk(Clk), .Rst(Rst),
      .DF_Req(DF_Req), .DF_Addr(DF_Addr), .DF_Gnt(DF_Gnt),
      .DF_FirstWord(DF_FirstWord), .DF_Completed(DF_Completed),
      .IF_Req(IF_Req), .IF_Addr(IF_Addr), .IF_Gnt(IF_Gnt),
      .IF_FirstWord(IF_FirstWord), .IF_Completed(IF_Completed),
      .DW_Req(DW_Req), .DW_Addr(DW_Addr), .DW_WData(DW_WData), .DW_Beat(DW_Beat),
      .DW_Gnt(DW_Gnt), .DW_Completed(DW_Completed),
      .RData(RData), .RValid(RValid), .RWord(RWord),
      .Mem_Req(Mem_Req), .Mem_RW(Mem_RW), .Mem_Addr(Mem_Addr),
      .Mem_WData(Mem_WData), .Mem_RData(Mem_RData), .Mem_Ack(Mem_Ack)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic set_req(input int c, input logic v);
      case (c)
         0:       DF_Req = v;
         1:       IF_Req = v;
         default: DW_Req = v;
      endcase
   endtask

   // Expected beats for one burst; owner 0=DF, 1=IF, 2=DW.
   task automatic push_burst(input int owner, input logic [31:0] addr);
      logic [31:0] base;
      int          start;
      base  = addr & ~32'(WPL * 4 - 1);
      start = (owner == 2) ? 0 : int'(addr[4:2]);
      for (int i = 0; i < WPL; i++) begin
         beat_t e;
         e.rw    = (owner == 2);
         e.owner = owner;
         e.beat  = i;
         e.word  = (start + i) % WPL;
         e.addr  = base | 32'(e.word * 4);
         sb.push_back(e);
      end
   endtask

   task automatic monitor_step();
      logic [2:0] g;
      beat_t      e;
      @(negedge Clk);
      g = {DW_Gnt, IF_Gnt, DF_Gnt};
      chk("gnt_onehot", 32'($onehot0(g)), 32'd1);
      if (prev_cpl) begin
         chk("bubble_gnt", {29'd0, g}, 32'd0);
         chk("bubble_mreq", 32'(Mem_Req), 32'd0);
      end
      if (Mem_Req && Mem_Ack) begin
         if (sb.size() == 0)
            chk("unexpected_beat", 32'(sb.size()), 32'd1);
         else begin
            e = sb.pop_front();
            chk("mem_addr", Mem_Addr, e.addr);
            chk("mem_rw", 32'(Mem_RW), 32'(e.rw));
            chk("gnt_owner", {29'd0, g}, 32'(1 << e.owner));
            if (!e.rw) begin
               chk("rvalid", 32'(RValid), 32'd1);
               chk("rword", 32'(RWord), 32'(e.word));
               chk("rdata", RData, rd_data(e.addr));
               chk("firstword", 32'(e.owner == 0 ? DF_FirstWord : IF_FirstWord), 32'(e.beat == 0));
               chk("rd_completed", 32'(e.owner == 0 ? DF_Completed : IF_Completed), 32'(e.beat == WPL - 1));
            end else begin
               chk("wdata", Mem_WData, 32'hD000_0000 | 32'(e.beat));
               chk("dw_beat", 32'(DW_Beat), 32'(e.beat));
               chk("dw_completed", 32'(DW_Completed), 32'(e.beat == WPL - 1));
               chk("wr_rvalid", 32'(RValid), 32'd0);
            end
         end
      end else begin
         chk("idle_strobes", {26'd0, DF_FirstWord, IF_FirstWord, DF_Completed,
                              IF_Completed, DW_Completed, RValid}, 32'd0);
      end
      prev_cpl = DF_Completed | IF_Completed | DW_Completed;
   endtask

   // Run until all queued beats are seen; clients drop Req after Completed
   // and, while rearms remain, re-raise it once another client is granted.
   task automatic service(input int max_cyc, input int rearms_in);
      int         rearms;
      bit         dropped [3];
      logic [2:0] pg, g, cpl;
      bit         done;
      rearms = rearms_in;
      pg     = '0;
      done   = 1'b0;
      for (int k = 0; k < 3; k++) dropped[k] = 1'b0;
      for (int c = 0; c < max_cyc && !done; c++) begin
         @(negedge Clk);
         g   = {DW_Gnt, IF_Gnt, DF_Gnt};
         cpl = {DW_Completed, IF_Completed, DF_Completed};
         if (sb.size() == 0 && !DF_Req && !IF_Req && !DW_Req && g == 3'd0 && !Mem_Req)
            done = 1'b1;
         else begin
            step();
            for (int k = 0; k < 3; k++)
               if (cpl[k]) begin
                  set_req(k, 1'b0);
                  dropped[k] = (rearms > 0);
               end
            for (int k = 0; k < 3; k++)
               if (g[k] && !pg[k])
                  for (int j = 0; j < 3; j++)
                     if (j != k && dropped[j] && rearms > 0) begin
                        set_req(j, 1'b1);
                        dropped[j] = 1'b0;
                        rearms--;
                     end
         end
         pg = g;
      end
      chk("service_done", 32'(done), 32'd1);
   endtask

   initial begin
      bit seen;
      fork
         forever monitor_step();
      join_none

      // Reset state
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_gnt", {29'd0, DW_Gnt, IF_Gnt, DF_Gnt}, 32'd0);
      chk("rst_mreq", 32'(Mem_Req), 32'd0);
      chk("rst_maddr", Mem_Addr, 32'd0);
      Rst = 1'b1;
      step();

      // T1: single DF at word 5, latency and wrap order
      DF_Addr = 32'h1000_0034;
      DF_Req  = 1'b1;
      push_burst(0, DF_Addr);
      @(negedge Clk);
      chk("lat_c0_gnt", 32'(DF_Gnt), 32'd0);
      @(negedge Clk);
      chk("lat_arb_gnt", 32'(DF_Gnt), 32'd0);
      chk("lat_arb_mreq", 32'(Mem_Req), 32'd0);
      @(negedge Clk);
      chk("lat_gnt", 32'(DF_Gnt), 32'd1);
      chk("lat_gnt_mreq", 32'(Mem_Req), 32'd0);
      @(negedge Clk);
      chk("lat_mreq", 32'(Mem_Req), 32'd1);
      service(100, 0);

      // T2: DF and IF together
      step();
      DF_Addr = 32'h2000_0000;
      IF_Addr = 32'h3000_0048;
`ifdef ARB_ROUND_ROBIN_EN
      push_burst(1, IF_Addr);
      push_burst(0, DF_Addr);
`else
      push_burst(0, DF_Addr);
      push_burst(1, IF_Addr);
`endif
      DF_Req = 1'b1;
      IF_Req = 1'b1;
      service(200, 0);

`ifndef ARB_ROUND_ROBIN_EN
      // T3: DW starved by alternating DF/IF, forced on 5th arbitration
      step();
      DF_Addr = 32'h5000_0010;
      IF_Addr = 32'h6000_0020;
      DW_Addr = 32'h4000_0000;
      push_burst(0, DF_Addr);
      push_burst(1, IF_Addr);
      push_burst(0, DF_Addr);
      push_burst(1, IF_Addr);
      push_burst(2, DW_Addr);
      push_burst(0, DF_Addr);
      DF_Req = 1'b1;
      IF_Req = 1'b1;
      DW_Req = 1'b1;
      service(400, 3);
`endif

      // T4: dirty miss, write-back before fill of the same line
      step();
      DW_Addr = 32'h7000_0040;
      DF_Addr = 32'h7000_0054;
      push_burst(2, DW_Addr);
      push_burst(0, DF_Addr);
      DW_Req = 1'b1;
      DF_Req = 1'b1;
      service(200, 0);

      // T5: stall mid-burst, then reset
      step();
      ack_en  = 1'b0;
      DF_Addr = 32'h8000_0008;
      push_burst(0, DF_Addr);
      DF_Req  = 1'b1;
      seen    = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge Clk);
         seen = Mem_Req;
      end
      chk("t5_mreq_seen", 32'(seen), 32'd1);
      step();
      ack_en = 1'b1;
      repeat (3) step();
      ack_en = 1'b0;
      repeat (10) step();
      chk("stall_mreq", 32'(Mem_Req), 32'd1);
      chk("stall_gnt", 32'(DF_Gnt), 32'd1);
      chk("stall_beats_left", 32'(sb.size()), 32'(WPL - 3));
      Rst = 1'b0;
      #1;
      chk("ar_gnt", {29'd0, DW_Gnt, IF_Gnt, DF_Gnt}, 32'd0);
      chk("ar_strobes", {27'd0, DF_FirstWord, IF_FirstWord, DF_Completed, IF_Completed, DW_Completed}, 32'd0);
      chk("ar_mreq_rw", {30'd0, Mem_Req, Mem_RW}, 32'd0);
      chk("ar_maddr", Mem_Addr, 32'd0);
      chk("ar_wdata", Mem_WData, 32'd0);
      chk("ar_rdata", RData, 32'd0);
      chk("ar_rvalid_word_beat", {25'd0, RValid, RWord, DW_Beat}, 32'd0);
      sb.delete();
      DF_Req = 1'b0;
      ack_en = 1'b1;
      repeat (2) step();
      Rst = 1'b1;
      step();

`ifdef ARB_ROUND_ROBIN_EN
      // T6: all three held, rotating order from reset
      DF_Addr = 32'hB000_0000;
      IF_Addr = 32'hC000_0004;
      DW_Addr = 32'hA000_0000;
      push_burst(0, DF_Addr);
      push_burst(1, IF_Addr);
      push_burst(2, DW_Addr);
      push_burst(0, DF_Addr);
      push_burst(1, IF_Addr);
      DF_Req = 1'b1;
      IF_Req = 1'b1;
      DW_Req = 1'b1;
      service(400, 2);
`else
      // T6: normal service after reset, IF at last word
      IF_Addr = 32'h9000_001C;
      push_burst(1, IF_Addr);
      IF_Req = 1'b1;
      service(100, 0);
`endif

      repeat (3) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between three line-transfer clients: D-cache LineFill buffer (DF), I-cache LineFill buffer (IF) and D-cache LineWrite buffer (DW).
- Sequences one line burst at a time.
- Read bursts are critical-word-first with wrap-around.
- Generates the FirstWord and Completed strobes that the cache controllers use to release stalls and leave their wait states.

Parameters:
- WORDS_PER_LINE, 8, words per cache line; power of 2, at least 2
- ADDR_W, 32, byte address width
- MAX_SKIP, 4, consecutive DF/IF grants allowed while DW waits before DW is forced

Ports:
- Clk  in  1  clock
- Rst  in  1  asynchronous reset, active-low
- DF_Req  in  1  D-cache fill request; held until DF_Completed
- DF_Addr  in  ADDR_W  critical word byte address
- DF_Gnt  out  1  DF owns the port
- DF_FirstWord  out  1  one-cycle pulse on beat 0 (critical word)
- DF_Completed  out  1  one-cycle pulse on the last beat
- IF_Req, IF_Addr, IF_Gnt, IF_FirstWord, IF_Completed  same as DF
- DW_Req  in  1  write-back request
- DW_Addr  in  ADDR_W  line base address
- DW_WData  in  32  write beat data, indexed by DW_Beat
- DW_Beat  out  log2(WORDS_PER_LINE)  current write beat index
- DW_Gnt  out  1  DW owns the port
- DW_Completed  out  1  one-cycle pulse on the last beat
- RData  out  32  read beat data, shared by DF and IF
- RValid  out  1  RData valid for the granted reader
- RWord  out  log2(WORDS_PER_LINE)  word index of RData within the line
- Mem_Req  out  1  beat request
- Mem_RW  out  1  1 = write, 0 = read
- Mem_Addr  out  ADDR_W  word-aligned beat address
- Mem_WData  out  32  write data
- Mem_RData  in  32  read data
- Mem_Ack  in  1  beat accepted / read data valid

Behaviour:
- Reset (Rst low, asynchronous): all outputs 0; state IDLE; beat counter 0; skip counter 0. Reset mid-burst abandons the burst and emits no Completed pulse.
- State machine IDLE -> ARB -> BURST -> IDLE:
  - IDLE: on any Req, go to ARB next cycle.
  - ARB: select the winner and register Gnt.
    - Default priority DF > IF > DW.
    - If skip counter = MAX_SKIP and DW_Req is high, DW wins.
    - Skip counter increments on each DF/IF grant while DW_Req is high; it clears on any DW grant or when DW_Req is low.
  - ARB latches the owner's address.
    - Reader start word = Addr[log2(WORDS_PER_LINE)+1:2].
    - DW starts at word 0.
  - BURST: Mem_Req is held high. Mem_Addr = {line base, word index, 2'b00}.
  - Each Mem_Ack completes a beat:
    - beat counter +1;
    - word index = (start + beat) mod WORDS_PER_LINE, wrapping from the last word to word 0.
  - Reads: RValid = Mem_Ack, RData = Mem_RData, RWord = word index.
    - FirstWord pulses in the same cycle as the first Ack.
  - Writes: Mem_WData = DW_WData; DW_Beat = beat counter.
  - On the Ack for beat WORDS_PER_LINE-1:
    - Completed pulses;
    - Gnt drops next cycle;
    - go to IDLE if no Req is pending, otherwise to ARB. Minimum of one bubble cycle between bursts.
- Latency: at least 2 cycles from Req to the first Mem_Req (IDLE->ARB->BURST); the first Mem_Req rises in the cycle after Gnt.
- Gnt is exclusive: at most one Gnt is high in any cycle.
- A Req that deasserts mid-burst is ignored; the burst runs to completion.
- Simultaneous requests: DF and IF both requesting in IDLE -> DF is served first, then IF.
- Same-line rule: DF and DW requests for the same line (dirty miss) are served DW first whenever both are pending at ARB with equal line address, overriding priority. This prevents a fill from returning stale memory data.
- Mem_Ack held low indefinitely stalls the burst; no timeout.

Optional Feature:
- ARB_ROUND_ROBIN_EN
  - Defined: ARB uses rotating priority DF -> IF -> DW, starting after the last granted client. The skip counter and MAX_SKIP are unused. The same-line rule still applies.
  - Undefined: fixed priority with the MAX_SKIP starvation guard, as described above.

Decomposition:
- Shared package (mem_arb_pkg): client ID encoding (DF=0, IF=1, DW=2), state encoding, and the BEAT_W = log2(WORDS_PER_LINE) constant.
- Sub-module arb_beat_counter: beat counter plus wrap-around word index generator. Inputs: start word, load, Ack. Outputs: beat index, word index, last-beat flag.

Test Plan:
- Single DF_Req at word 5 (Addr 0x1000_0034), Ack every cycle:
  - Mem_Addr sequence 0x34,0x38,0x3C,0x20,...,0x30;
  - DF_FirstWord with RWord=5;
  - DF_Completed on the 8th Ack.
- DF_Req and IF_Req asserted in the same cycle -> DF burst fully, one bubble, then IF burst; never both Gnt high.
- DW_Req held while DF/IF alternate requests continuously -> DW granted on the 5th arbitration (MAX_SKIP=4).
- Dirty miss: DW_Req and DF_Req to the same line in the same cycle:
  - DW burst (Mem_RW=1, words 0..7, DW_Beat 0..7) before the DF burst.
- Ack withheld for 10 cycles mid-burst, then Rst pulsed low:
  - all outputs 0 immediately;
  - no Completed pulse;
  - new Req after reset is served normally.
- With ARB_ROUND_ROBIN_EN defined and all three requests held -> grant order DF, IF, DW, DF.
